// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with optional skid entry, flush/hold and perf counters
module pipe_stage_elastic #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 16,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              hold,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam bit SKID = (SKID_EN != 0);

  logic              main_valid, main_valid_n;
  logic              skid_valid, skid_valid_n;
  logic              rdy_q, rdy_n;
  logic [DATA_W-1:0] main_data, main_data_n, skid_data, skid_data_n;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_n, skid_ctrl, skid_ctrl_n;
  logic              acc, lv, main_free;
  logic              inc_stall, inc_bubble, inc_flush;

  // rdy_q is low through reset and, with the skid enabled, mirrors an empty skid slot
  assign out_valid = main_valid && !hold;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign in_ready  = rdy_q && !hold && (SKID || !out_valid || out_ready);

  assign acc       = in_valid && in_ready && !flush;
  assign lv        = out_valid && out_ready;
  assign main_free = !main_valid || lv;

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    main_ctrl_n  = main_ctrl;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_ctrl_n  = skid_ctrl;
    if (flush) begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
      skid_valid_n = 1'b0;
      skid_ctrl_n  = '0;
    end else if (main_free) begin
      // a waiting skid entry always beats new input; in_ready is low while it exists
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        main_ctrl_n  = skid_ctrl;
        skid_valid_n = 1'b0;
      end else if (acc) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
        main_ctrl_n  = in_ctrl;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (acc && SKID) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
      skid_ctrl_n  = in_ctrl;
    end
    rdy_n = SKID ? !skid_valid_n : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      main_ctrl  <= main_ctrl_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_ctrl  <= skid_ctrl_n;
      rdy_q      <= rdy_n;
    end
  end

  assign inc_stall  = out_valid && !out_ready && (stall_cnt != '1);
  assign inc_bubble = !out_valid && (bubble_cnt != '1);
  assign inc_flush  = flush && (flush_cnt != '1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (inc_stall)  stall_cnt  <= stall_cnt + CNT_W'(1);
      if (inc_bubble) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (inc_flush)  flush_cnt  <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic, skid and single-register variants
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [15:0] in_ctrl = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_data_a, out_data_b;
  logic [15:0] out_ctrl_a, out_ctrl_b;
  logic [15:0] stall_a, bubble_a, flush_a;
  logic [3:0]  stall_b, bubble_b, flush_b;

  int checks = 0;
  int failures = 0;
  logic [47:0] q_a[$];
  logic [47:0] q_b[$];
  logic [47:0] exp_a, exp_b;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_ctrl(out_ctrl_a), .flush(flush), .hold(hold), .clr_cnt(clr_cnt),
    .stall_cnt(stall_a), .bubble_cnt(bubble_a), .flush_cnt(flush_a)
  );

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(16), .SKID_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_ctrl(out_ctrl_b), .flush(flush), .hold(hold), .clr_cnt(clr_cnt),
    .stall_cnt(stall_b), .bubble_cnt(bubble_b), .flush_cnt(flush_b)
  );

  // scoreboard: push on accepted input, pop on delivered output, flush/reset empty the queues
  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (out_valid_a && out_ready) begin
        checks++;
        if (q_a.size() == 0) begin failures++; $display("FAIL sb_a_extra: got %h/%h want no output", out_ctrl_a, out_data_a); end
        else begin
          exp_a = q_a.pop_front();
          if ({out_ctrl_a, out_data_a} !== exp_a) begin failures++; $display("FAIL sb_a_data: got %h want %h", {out_ctrl_a, out_data_a}, exp_a); end
        end
      end
      if (out_valid_b && out_ready) begin
        checks++;
        if (q_b.size() == 0) begin failures++; $display("FAIL sb_b_extra: got %h/%h want no output", out_ctrl_b, out_data_b); end
        else begin
          exp_b = q_b.pop_front();
          if ({out_ctrl_b, out_data_b} !== exp_b) begin failures++; $display("FAIL sb_b_data: got %h want %h", {out_ctrl_b, out_data_b}, exp_b); end
        end
      end
      if (!out_valid_a) begin checks++; if (out_ctrl_a !== '0) begin failures++; $display("FAIL bubble_ctrl_a: got %h want 0", out_ctrl_a); end end
      if (!out_valid_b) begin checks++; if (out_ctrl_b !== '0) begin failures++; $display("FAIL bubble_ctrl_b: got %h want 0", out_ctrl_b); end end
      if (flush) begin
        q_a.delete();
        q_b.delete();
      end else begin
        if (in_valid && in_ready_a) q_a.push_back({in_ctrl, in_data});
        if (in_valid && in_ready_b) q_b.push_back({in_ctrl, in_data});
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_counters();
    in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b1;
    nxt();
    clr_cnt = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; hold = 1'b0; clr_cnt = 1'b0;
    repeat (3) nxt();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hdead; in_ctrl = 16'hffff; out_ready = 1'b0;
    nxt(); nxt(); mid();
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL rst_in_ready_a: got %b want 0", in_ready_a); end
    checks++; if (in_ready_b !== 1'b0) begin failures++; $display("FAIL rst_in_ready_b: got %b want 0", in_ready_b); end
    checks++; if (out_data_a !== 32'h0) begin failures++; $display("FAIL rst_out_data: got %h want 0", out_data_a); end
    checks++; if (out_ctrl_a !== 16'h0) begin failures++; $display("FAIL rst_out_ctrl: got %h want 0", out_ctrl_a); end
    checks++; if ({stall_a, bubble_a, flush_a} !== 48'h0) begin failures++; $display("FAIL rst_counters: got %h want 0", {stall_a, bubble_a, flush_a}); end
    nxt();
    rst_n = 1'b1; in_valid = 1'b0;
    mid();
    checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL rst_release_ready: got %b want 0", in_ready_a); end
    nxt(); mid();
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL rst_ready_a_up: got %b want 1", in_ready_a); end
    checks++; if (in_ready_b !== 1'b1) begin failures++; $display("FAIL rst_ready_b_up: got %b want 1", in_ready_b); end
    checks++; if (bubble_a !== 16'd1) begin failures++; $display("FAIL rst_bubble_first: got %0d want 1", bubble_a); end
    nxt();
  endtask

  task automatic test_stream();
    clear_counters();
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      in_data = 32'h10 + 32'(k);
      in_ctrl = 16'($urandom);
      mid();
      if (k < 8) begin
        checks++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d: got %b%b want 11", k, in_ready_a, in_ready_b); end
      end
      if (k == 0) begin
        checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin failures++; $display("FAIL stream_latency: got %b%b want 00", out_valid_a, out_valid_b); end
      end else begin
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 32'h10 + 32'(k - 1)) begin failures++; $display("FAIL stream_a k=%0d: got %b/%h want 1/%h", k, out_valid_a, out_data_a, 32'h10 + 32'(k - 1)); end
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 32'h10 + 32'(k - 1)) begin failures++; $display("FAIL stream_b k=%0d: got %b/%h want 1/%h", k, out_valid_b, out_data_b, 32'h10 + 32'(k - 1)); end
      end
      nxt();
    end
    mid();
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL stream_end_valid: got %b want 0", out_valid_a); end
    checks++; if (bubble_a !== 16'd1) begin failures++; $display("FAIL stream_bubble_a: got %0d want 1", bubble_a); end
    checks++; if (bubble_b !== 4'd1) begin failures++; $display("FAIL stream_bubble_b: got %0d want 1", bubble_b); end
    checks++; if (stall_a !== 16'd0) begin failures++; $display("FAIL stream_stall_a: got %0d want 0", stall_a); end
    nxt();
  endtask

  task automatic test_backpressure();
    logic [31:0] want_data [7];
    logic        want_rdy [7];
    logic        iv [7];
    logic        ordy [7];
    want_data = '{32'h0, 32'hA, 32'hA, 32'hA, 32'hA, 32'hB, 32'h0};
    want_rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    iv        = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ordy      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clear_counters();
    for (int k = 0; k < 7; k++) begin
      in_valid = iv[k];
      in_data = (k == 0) ? 32'hA : 32'hB;
      in_ctrl = 16'($urandom);
      out_ready = ordy[k];
      mid();
      checks++; if (in_ready_a !== want_rdy[k]) begin failures++; $display("FAIL bp_ready k=%0d: got %b want %b", k, in_ready_a, want_rdy[k]); end
      if (k >= 1 && k <= 5) begin
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== want_data[k]) begin failures++; $display("FAIL bp_order k=%0d: got %b/%h want 1/%h", k, out_valid_a, out_data_a, want_data[k]); end
      end
      if (k == 4 || k == 6) begin
        checks++; if (stall_a !== 16'd3) begin failures++; $display("FAIL bp_stall k=%0d: got %0d want 3", k, stall_a); end
      end
      nxt();
    end
  endtask

  task automatic test_flush();
    clear_counters();
    in_valid = 1'b1; in_data = 32'h21; in_ctrl = 16'h8001;
    nxt();
    in_data = 32'h22; in_ctrl = 16'h8002;
    mid();
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL flush_fill_ready: got %b want 1", in_ready_a); end
    nxt();
    flush = 1'b1; in_data = 32'h23; in_ctrl = 16'h8003;
    mid();
    checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL flush_skid_full: got %b want 0", in_ready_a); end
    nxt();
    flush = 1'b0; in_valid = 1'b0;
    mid();
    checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b%b want 00", out_valid_a, out_valid_b); end
    checks++; if (out_ctrl_a !== 16'h0) begin failures++; $display("FAIL flush_ctrl: got %h want 0", out_ctrl_a); end
    checks++; if (out_data_a !== 32'h21) begin failures++; $display("FAIL flush_data_kept: got %h want 21", out_data_a); end
    checks++; if (flush_a !== 16'd1) begin failures++; $display("FAIL flush_cnt1: got %0d want 1", flush_a); end
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL flush_ready_back: got %b want 1", in_ready_a); end
    nxt();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h24; in_ctrl = 16'h8004; out_ready = 1'b1;
    mid();
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b want 1", in_ready_a); end
    nxt();
    flush = 1'b0; in_valid = 1'b0;
    mid();
    checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin failures++; $display("FAIL flush_discard: got %b%b want 00", out_valid_a, out_valid_b); end
    checks++; if (out_data_a !== 32'h21) begin failures++; $display("FAIL flush_discard_data: got %h want 21", out_data_a); end
    checks++; if (flush_a !== 16'd2 || flush_b !== 4'd2) begin failures++; $display("FAIL flush_cnt2: got %0d/%0d want 2/2", flush_a, flush_b); end
    nxt();
  endtask

  task automatic test_hold();
    int seen;
    seen = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'h0155;
    nxt();
    for (int k = 1; k <= 5; k++) begin
      hold = (k <= 2);
      in_valid = (k <= 2);
      in_data = 32'h66; in_ctrl = 16'h0166;
      mid();
      if (k <= 2) begin
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin failures++; $display("FAIL hold_a k=%0d: got %b%b want 00", k, out_valid_a, in_ready_a); end
        checks++; if (out_valid_b !== 1'b0 || in_ready_b !== 1'b0) begin failures++; $display("FAIL hold_b k=%0d: got %b%b want 00", k, out_valid_b, in_ready_b); end
      end
      if (k == 3) begin
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 32'h55) begin failures++; $display("FAIL hold_resume_a: got %b/%h want 1/55", out_valid_a, out_data_a); end
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 32'h55) begin failures++; $display("FAIL hold_resume_b: got %b/%h want 1/55", out_valid_b, out_data_b); end
      end
      if (out_valid_a && out_data_a == 32'h55) seen++;
      nxt();
    end
    checks++; if (seen != 1) begin failures++; $display("FAIL hold_once: got %0d deliveries want 1", seen); end
  endtask

  task automatic test_saturation();
    clear_counters();
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'h0077;
    nxt();
    in_valid = 1'b0;
    repeat (20) nxt();
    clr_cnt = 1'b1;
    mid();
    checks++; if (stall_b !== 4'd15) begin failures++; $display("FAIL sat_stall_b: got %0d want 15", stall_b); end
    checks++; if (stall_a !== 16'd20) begin failures++; $display("FAIL sat_stall_a: got %0d want 20", stall_a); end
    nxt();
    clr_cnt = 1'b0;
    mid();
    checks++; if (stall_b !== 4'd0 || stall_a !== 16'd0) begin failures++; $display("FAIL clr_stall: got %0d/%0d want 0/0", stall_b, stall_a); end
    checks++; if (in_ready_b !== 1'b0) begin failures++; $display("FAIL noskid_full_ready: got %b want 0", in_ready_b); end
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL skid_free_ready: got %b want 1", in_ready_a); end
    nxt();
    out_ready = 1'b1;
    mid();
    checks++; if (stall_b !== 4'd1) begin failures++; $display("FAIL stall_after_clr: got %0d want 1", stall_b); end
    checks++; if (in_ready_b !== 1'b1 || out_valid_b !== 1'b1 || out_data_b !== 32'h77) begin failures++; $display("FAIL noskid_follow: got %b%b/%h want 11/77", in_ready_b, out_valid_b, out_data_b); end
    nxt();
  endtask

  task automatic test_reset_mid();
    clear_counters();
    in_valid = 1'b1; in_data = 32'h31;
    nxt();
    in_data = 32'h32;
    nxt();
    rst_n = 1'b0; in_data = 32'h33;
    nxt();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mid();
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin failures++; $display("FAIL rstmid_state: got %b%b want 00", out_valid_a, in_ready_a); end
    checks++; if ({stall_a, bubble_a, flush_a} !== 48'h0) begin failures++; $display("FAIL rstmid_counters: got %h want 0", {stall_a, bubble_a, flush_a}); end
    checks++; if (out_data_a !== 32'h0) begin failures++; $display("FAIL rstmid_data: got %h want 0", out_data_a); end
    nxt(); mid();
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin failures++; $display("FAIL rstmid_after: got %b%b want 01", out_valid_a, in_ready_a); end
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    drain();
    test_backpressure();
    drain();
    test_flush();
    drain();
    test_hold();
    drain();
    test_saturation();
    drain();
    test_reset_mid();
    drain();
    checks++; if (q_a.size() != 0 || q_b.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d/%0d entries want 0/0", q_a.size(), q_b.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
